// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the CPU
// fetch path, the CPU load/store path and the video scan-out reader.
// Grants are combinational, at most one per cycle. A wait counter promotes
// video to top priority so that CPU traffic cannot starve it.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int VID_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vid_urgent
);

  localparam logic [3:0] MAX_WAIT = 4'(VID_MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              urgent;
  logic              any_gnt;

  assign urgent     = (wait_cnt == MAX_WAIT);
  assign vid_urgent = urgent;
  assign any_gnt    = if_gnt | ls_gnt | vid_gnt;

  // Priority select: video first once its wait has saturated, else ls > if > vid
  always_comb begin
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    vid_gnt = 1'b0;
    if (!reset) begin
      if (urgent && vid_req)  vid_gnt = 1'b1;
      else if (ls_req)        ls_gnt  = 1'b1;
      else if (if_req)        if_gnt  = 1'b1;
      else if (vid_req)       vid_gnt = 1'b1;
    end
  end

  // Address mux; an idle cycle keeps the previous address on the RAM bus
  always_comb begin
    mem_addr = last_addr;
    if (ls_gnt)       mem_addr = ls_addr;
    else if (if_gnt)  mem_addr = if_addr;
    else if (vid_gnt) mem_addr = vid_addr;
  end

  // Only the load/store path ever writes; video and fetch are read-only
  assign mem_wdata = ls_wdata;
  assign mem_we    = ls_gnt & ls_we;

  // Read data is the raw RAM output; the rvalid strobes say who owns it
  assign rdata = mem_rdata;

  // Video wait counter: clears on withdrawal or grant, saturates at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt <= 4'd0;
    else if (!vid_req || vid_gnt) wait_cnt <= 4'd0;
    else if (!urgent)            wait_cnt <= wait_cnt + 4'd1;
  end

  // Remember the last granted address for idle cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_addr <= '0;
    else if (any_gnt) last_addr <= mem_addr;
  end

  // Return pipeline: RAM data arrives one cycle after the grant; stores get no strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      vid_rvalid <= 1'b0;
    end else begin
      if_rvalid  <= if_gnt;
      ls_rvalid  <= ls_gnt & ~ls_we;
      vid_rvalid <= vid_gnt;
    end
  end

endmodule
